// File: rtl/ysyx_22050612_regfile_sb.sv
// ysyx_22050612_regfile_sb: multi-read dual-write register file with busy-bit scoreboard
module ysyx_22050612_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w0_en,
  input  logic [ADDR_WIDTH-1:0]       w0_addr,
  input  logic [DATA_WIDTH-1:0]       w0_data,
  input  logic                        w1_en,
  input  logic [ADDR_WIDTH-1:0]       w1_addr,
  input  logic [DATA_WIDTH-1:0]       w1_data,
  input  logic [NREAD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NREAD*DATA_WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]            rd_busy,
  input  logic                        sb_set_en,
  input  logic [ADDR_WIDTH-1:0]       sb_set_addr,
  output logic [2**ADDR_WIDTH-1:0]    busy_vec
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = (ZERO_REG != 0 && r == 0) ? '0 :
                  (w1_en && w1_addr == ADDR_WIDTH'(r)) ? w1_data :
                  (w0_en && w0_addr == ADDR_WIDTH'(r)) ? w0_data : regs_q[r];
      busy_d[r] = (ZERO_REG == 0 || r != 0) &&
                  ((sb_set_en && sb_set_addr == ADDR_WIDTH'(r)) ||
                   (busy_q[r] && !(w0_en && w0_addr == ADDR_WIDTH'(r)) &&
                    !(w1_en && w1_addr == ADDR_WIDTH'(r))));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end
  assign busy_vec = busy_q;
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic h0, h1, z;
    assign a = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign h1 = BYPASS != 0 && w1_en && w1_addr == a;
    assign h0 = BYPASS != 0 && w0_en && w0_addr == a;
    assign z = rst || (ZERO_REG != 0 && a == '0);
    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = z ? '0 : h1 ? w1_data : h0 ? w0_data : regs_q[a];
    assign rd_busy[g] = !rst && !h0 && !h1 && busy_q[a];
  end
endmodule

// File: tb/tb_ysyx_22050612_regfile_sb.sv
// tb_ysyx_22050612_regfile_sb: random and directed checks of the register file against a reference model
module tb_ysyx_22050612_regfile_sb;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst, w0_en, w1_en, sb_set_en;
  logic [4:0] w0_addr, w1_addr, sb_set_addr;
  logic [63:0] w0_data, w1_data;
  logic [9:0] rd_addr;
  logic [127:0] rd_data;
  logic [1:0] rd_busy;
  logic [31:0] busy_vec;
  logic v_rst, v_w0_en, v_w1_en, v_sb_set_en;
  logic [4:0] v_w0_addr, v_w1_addr, v_sb_set_addr;
  logic [31:0] v_w0_data, v_w1_data;
  logic [14:0] v_rd_addr;
  logic [95:0] v_rd_data;
  logic [2:0] v_rd_busy;
  logic [31:0] v_busy_vec;
  ysyx_22050612_regfile_sb u_dut (
    .clk(clk), .rst(rst),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .busy_vec(busy_vec)
  );
  ysyx_22050612_regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(3), .ZERO_REG(0), .BYPASS(0)) u_var (
    .clk(clk), .rst(v_rst),
    .w0_en(v_w0_en), .w0_addr(v_w0_addr), .w0_data(v_w0_data),
    .w1_en(v_w1_en), .w1_addr(v_w1_addr), .w1_data(v_w1_data),
    .rd_addr(v_rd_addr), .rd_data(v_rd_data), .rd_busy(v_rd_busy),
    .sb_set_en(v_sb_set_en), .sb_set_addr(v_sb_set_addr), .busy_vec(v_busy_vec)
  );
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  logic [63:0] mregs [32];
  logic [31:0] mbusy;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (rst || a == 0) return '0;
    if (w1_en && w1_addr == a) return w1_data;
    if (w0_en && w0_addr == a) return w0_data;
    return mregs[a];
  endfunction
  function automatic logic exp_busy(input logic [4:0] a);
    if (rst || (w0_en && w0_addr == a) || (w1_en && w1_addr == a)) return 1'b0;
    return mbusy[a];
  endfunction
  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      mbusy = '0;
      foreach (mregs[k]) mregs[k] = '0;
    end else begin
      if (w0_en && w0_addr != 0) mregs[w0_addr] = w0_data;
      if (w1_en && w1_addr != 0) mregs[w1_addr] = w1_data;
      if (w0_en) mbusy[w0_addr] = 1'b0;
      if (w1_en) mbusy[w1_addr] = 1'b0;
      if (sb_set_en && sb_set_addr != 0) mbusy[sb_set_addr] = 1'b1;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("model rd_data", 128'(rd_data[i*64 +: 64]), 128'(exp_rd(rd_addr[i*5 +: 5])));
        chk("model rd_busy", 128'(rd_busy[i]), 128'(exp_busy(rd_addr[i*5 +: 5])));
      end
      chk("model busy_vec", 128'(busy_vec), 128'(mbusy));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    w0_en = 0; w1_en = 0; sb_set_en = 0;
    v_w0_en = 0; v_w1_en = 0; v_sb_set_en = 0;
  endtask
  initial begin
    rst = 1; v_rst = 1; idle();
    w0_addr = 0; w1_addr = 0; sb_set_addr = 0; w0_data = 0; w1_data = 0; rd_addr = {5'd4, 5'd5};
    v_w0_addr = 0; v_w1_addr = 0; v_sb_set_addr = 0; v_w0_data = 0; v_w1_data = 0; v_rd_addr = 0;
    step(); step();
    chk_en = 1;
    @(negedge clk);
    chk("reset busy_vec", 128'(busy_vec), 128'h0);
    chk("reset rd_data", rd_data, 128'h0);
    step(); rst = 0;
    w0_en = 1; w0_addr = 5; w0_data = 64'hDEADBEEF; sb_set_en = 1; sb_set_addr = 5;
    step(); idle(); rd_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("r5 loaded", 128'(rd_data[63:0]), 128'hDEADBEEF);
    chk("r5 busy", 128'(busy_vec), 128'h20);
    step(); rst = 1; w0_en = 1; w0_addr = 5; w0_data = 64'h1111; sb_set_en = 1; sb_set_addr = 6;
    @(negedge clk);
    chk("rd during rst", 128'(rd_data[63:0]), 128'h0);
    chk("rd_busy during rst", 128'(rd_busy), 128'h0);
    step(); rst = 0; idle();
    @(negedge clk);
    chk("r5 after rst", 128'(rd_data[63:0]), 128'h0);
    chk("busy after rst", 128'(busy_vec), 128'h0);
    step(); w0_en = 1; w0_addr = 3; w0_data = 64'h1234; rd_addr = {5'd0, 5'd3};
    @(negedge clk);
    chk("bypass r3", 128'(rd_data[63:0]), 128'h1234);
    step(); idle();
    @(negedge clk);
    chk("stored r3", 128'(rd_data[63:0]), 128'h1234);
    step(); w0_en = 1; w0_addr = 7; w0_data = 64'hAAAA; w1_en = 1; w1_addr = 7; w1_data = 64'h5555;
    rd_addr = {5'd7, 5'd0};
    @(negedge clk);
    chk("collision bypass", 128'(rd_data[127:64]), 128'h5555);
    step(); idle();
    @(negedge clk);
    chk("collision stored", 128'(rd_data[127:64]), 128'h5555);
    step(); w1_en = 1; w1_addr = 0; w1_data = 64'hFFFF; sb_set_en = 1; sb_set_addr = 0; rd_addr = 0;
    @(negedge clk);
    chk("r0 bypass zero", 128'(rd_data[63:0]), 128'h0);
    step(); idle();
    @(negedge clk);
    chk("r0 stored zero", 128'(rd_data[63:0]), 128'h0);
    chk("r0 never busy", 128'(busy_vec[0]), 128'h0);
    step(); sb_set_en = 1; sb_set_addr = 9;
    step(); idle(); rd_addr = {5'd0, 5'd9};
    @(negedge clk);
    chk("r9 busy read", 128'(rd_busy[0]), 128'h1);
    step(); w0_en = 1; w0_addr = 9; w0_data = 64'h99; sb_set_en = 1; sb_set_addr = 9; rd_addr = {5'd9, 5'd9};
    @(negedge clk);
    chk("rd_busy write cycle", 128'(rd_busy), 128'h0);
    step(); idle();
    @(negedge clk);
    chk("set wins race", 128'(busy_vec[9]), 128'h1);
    step(); w1_en = 1; w1_addr = 9; w1_data = 64'h77; rd_addr = {5'd9, 5'd0};
    @(negedge clk);
    chk("rd_busy w1 cycle", 128'(rd_busy[1]), 128'h0);
    step(); idle();
    @(negedge clk);
    chk("r9 cleared", 128'(busy_vec[9]), 128'h0);
    chk("r9 data", 128'(rd_data[127:64]), 128'h77);
    repeat (3000) begin
      step();
      rst = ($urandom_range(0, 49) == 0);
      w0_en = 1'($urandom_range(0, 1)); w0_addr = rnd_addr(); w0_data = {$urandom, $urandom};
      w1_en = 1'($urandom_range(0, 1)); w1_addr = rnd_addr(); w1_data = {$urandom, $urandom};
      sb_set_en = 1'($urandom_range(0, 1)); sb_set_addr = rnd_addr();
      rd_addr = {rnd_addr(), rnd_addr()};
    end
    step(); rst = 0; idle();
    v_rst = 0; v_w0_en = 1; v_w0_addr = 3; v_w0_data = 32'h1234; v_rd_addr = {5'd0, 5'd0, 5'd3};
    @(negedge clk);
    chk("nobypass old", 128'(v_rd_data[31:0]), 128'h0);
    step(); idle(); v_w1_en = 1; v_w1_addr = 0; v_w1_data = 32'hFFFF; v_sb_set_en = 1; v_sb_set_addr = 0;
    @(negedge clk);
    chk("nobypass new", 128'(v_rd_data[31:0]), 128'h1234);
    step(); idle(); v_rd_addr = 0;
    v_w0_en = 1; v_w0_addr = 1; v_w0_data = 32'h1; v_w1_en = 1; v_w1_addr = 2; v_w1_data = 32'h2;
    @(negedge clk);
    chk("r0 writable", 128'(v_rd_data[31:0]), 128'hFFFF);
    chk("r0 busy", 128'(v_busy_vec[0]), 128'h1);
    step(); idle(); v_w0_en = 1; v_w0_addr = 31; v_w0_data = 32'h80000000;
    step(); idle(); v_rd_addr = {5'd1, 5'd2, 5'd31};
    @(negedge clk);
    chk("multi-port read", 128'(v_rd_data), 128'h00000001_00000002_80000000);
    step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22050612_regfile_sb.md
Name: ysyx_22050612_regfile_sb

Overview:
- Parametrised multi-read, dual-write integer register file with an integrated busy-bit scoreboard for the pipelined NPC core.
- Sits between decode (reads, scoreboard set on issue) and writeback (two retire ports, e.g. ALU and LSU).
- Adds over the single-port file: synchronous clear, hardwired zero register, optional write-to-read bypass, per-register pending-write tracking.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, register width in bits.
- NREAD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- w0_en  in  1  write port 0 enable
- w0_addr  in  ADDR_WIDTH  write port 0 index
- w0_data  in  DATA_WIDTH  write port 0 data
- w1_en  in  1  write port 1 enable (priority port)
- w1_addr  in  ADDR_WIDTH  write port 1 index
- w1_data  in  DATA_WIDTH  write port 1 data
- rd_addr  in  NREAD*ADDR_WIDTH  packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NREAD*DATA_WIDTH  packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- rd_busy  out  NREAD  per-read-port pending-write flag
- sb_set_en  in  1  mark a destination as pending (instruction issue)
- sb_set_addr  in  ADDR_WIDTH  destination index to mark
- busy_vec  out  2**ADDR_WIDTH  full scoreboard, bit r = register r pending

Behaviour:
- Reset:
  - rst high at a rising edge clears every register to 0 and every busy bit to 0 in that edge.
  - While rst is high, writes and sb_set_en are ignored.
  - While rst is high, rd_data = 0 and rd_busy = 0 (bypass suppressed).
  - Reset asserted mid-operation discards all in-flight writes and sets.
- Writes:
  - Committed on the rising edge.
  - Both ports enabled to the same index: w1_data is stored, w0 discarded.
  - ZERO_REG=1: writes to index 0 are dropped.
- Reads:
  - Combinational, zero latency. Base value is the stored register.
  - BYPASS=1: if w1_en and w1_addr matches, return w1_data; else if w0_en and w0_addr matches, return w0_data.
  - BYPASS=0: the new value is visible the cycle after the write edge.
  - ZERO_REG=1 and rd_addr = 0: rd_data = 0 regardless of bypass.
- Scoreboard:
  - sb_set_en sets busy[sb_set_addr] on the edge.
  - Any enabled write clears busy[w_addr] on the edge.
  - Set and clear of the same index in the same cycle: set wins, because a new producer was issued.
  - ZERO_REG=1: busy[0] is held at 0 and sets to index 0 are dropped.
  - Setting an already-busy index leaves it at 1. There is no counting; one outstanding producer per register is the issue-stage contract.
  - busy_vec reflects registered state only.
  - rd_busy[i] = busy[rd_addr_i], forced to 0 when BYPASS=1 and a write to that index is enabled this cycle.
- Widths: all indices are unsigned. There is no out-of-range condition because depth = 2**ADDR_WIDTH.
- No $display or other simulation output in the block.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, set busy r5, assert rst for 1 cycle -> next cycle r5 reads 0, busy_vec = 0.
- Write/read with BYPASS=1: w0 writes 0x1234 to r3, rd_addr0 = 3 in the same cycle -> rd_data0 = 0x1234 combinationally, still 0x1234 the next cycle. Repeat with BYPASS=0 -> old value 0 in the write cycle, 0x1234 the next cycle.
- Port collision: w0 writes 0xAAAA and w1 writes 0x5555 to r7 in the same cycle -> r7 = 0x5555, and the bypass output in that cycle is 0x5555.
- Zero register: w1 writes 0xFFFF to r0 and sb_set_addr = 0 -> rd_data for r0 = 0, busy_vec[0] = 0. With ZERO_REG=0 -> r0 = 0xFFFF, busy_vec[0] = 1.
- Scoreboard race: busy r9 = 1; in one cycle w0 writes r9 and sb_set_en targets r9 -> busy r9 stays 1. In the next cycle w1 writes r9 with no set -> busy r9 = 0. In that write cycle rd_busy for a port reading r9 = 0 (BYPASS=1).
- Multi-port read (NREAD=3, DATA_WIDTH=32): load r1 = 1, r2 = 2, r31 = 0x80000000, read ports = {31, 2, 1} -> packed rd_data = {0x00000001, 0x00000002, 0x80000000}, with port 0 in the LSBs.
